// File: rtl/ctrl_sequencer.sv
// Multicycle Moore control unit for the ARM-subset datapath: fetch, decode and
// execute of data-processing, LDR/STR word and B/BL, with a memory wait timeout trap.
module ctrl_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        cond_true,
  input  logic        moc,
  output logic [1:0]  ma,
  output logic [1:0]  mb,
  output logic [2:0]  mc,
  output logic        md,
  output logic        me,
  output logic [1:0]  mf,
  output logic        mg,
  output logic        mh,
  output logic [1:0]  mi,
  output logic [1:0]  mj,
  output logic [4:0]  alu_op,
  output logic        rf_ld,
  output logic        ir_ld,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        mfa,
  output logic        rw,
  output logic        bus_err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_DP   = 4'd5,
    S_LSA  = 4'd6,
    S_LDW  = 4'd7,
    S_LWB  = 4'd8,
    S_STM  = 4'd9,
    S_STW  = 4'd10,
    S_BR   = 4'd11,
    S_BL2  = 4'd12,
    S_ERR  = 4'd15
  } state_t;

  localparam logic [4:0] ALU_SUB  = 5'h02;
  localparam logic [4:0] ALU_ADD  = 5'h04;
  localparam logic [4:0] ALU_PASS = 5'h0D;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             bus_err_reg, bus_err_next;
  logic             wait_st, timeout;
  logic             ir_unused;

  assign ir_unused = ^{ir[31:28], ir[22:21], ir[19:0]};

  assign wait_st = (state_reg == S_F2) || (state_reg == S_LDW) || (state_reg == S_STW);
  // A moc arriving on the final permitted cycle still completes the access.
  assign timeout = wait_st && !moc && (cnt_reg == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bus_err_reg <= bus_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: state_next = S_F0;
      S_F0:   state_next = S_F1;
      S_F1:   state_next = S_F2;
      S_F2:   state_next = moc ? S_DEC : (timeout ? S_ERR : S_F2);
      S_DEC: begin
        if (!cond_true)             state_next = S_F0;
        else if (ir[27:26] == 2'b00) state_next = S_DP;
        else if (ir[27:26] == 2'b01) state_next = S_LSA;
        else if (ir[27:25] == 3'b101) state_next = S_BR;
        else                        state_next = S_F0;
      end
      S_DP:   state_next = S_F0;
      S_LSA:  state_next = ir[20] ? S_LDW : S_STM;
      S_LDW:  state_next = moc ? S_LWB : (timeout ? S_ERR : S_LDW);
      S_LWB:  state_next = S_F0;
      S_STM:  state_next = S_STW;
      S_STW:  state_next = moc ? S_F0 : (timeout ? S_ERR : S_STW);
      S_BR:   state_next = ir[24] ? S_BL2 : S_F0;
      S_BL2:  state_next = S_F0;
      S_ERR:  state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  // Counter restarts on any state change, so every wait state is entered at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) cnt_next = '0;
    else if (wait_st && !moc)    cnt_next = cnt_reg + CNT_W'(1);
  end

  assign bus_err_next = bus_err_reg || (state_next == S_ERR);
  assign bus_err      = bus_err_reg;
  assign state        = state_reg;

  always_comb begin
    ma = 2'd0; mb = 2'd0; mc = 3'd0; md = 1'b0; me = 1'b0; mf = 2'd0;
    mg = 1'b0; mh = 1'b0; mi = 2'd0; mj = 2'd0; alu_op = 5'd0;
    rf_ld = 1'b0; ir_ld = 1'b0; mar_ld = 1'b0; mdr_ld = 1'b0;
    mfa = 1'b0; rw = 1'b0;
    case (state_reg)
      S_F0: begin
        ma = 2'd2; md = 1'b1; alu_op = ALU_PASS; mar_ld = 1'b1;
      end
      S_F1: begin
        ma = 2'd2; mb = 2'd3; md = 1'b1; alu_op = ALU_ADD; mc = 3'd3;
        rf_ld = 1'b1; mfa = 1'b1; rw = 1'b1;
      end
      S_F2: begin
        mfa = 1'b1; rw = 1'b1; mdr_ld = 1'b1; ir_ld = moc;
      end
      S_DP: begin
        mb = 2'd1; mc = 3'd1; rf_ld = (ir[24:23] != 2'b10);
      end
      S_LSA: begin
        md = 1'b1; alu_op = ir[23] ? ALU_ADD : ALU_SUB; mar_ld = 1'b1;
      end
      S_LDW: begin
        mfa = 1'b1; rw = 1'b1; mdr_ld = 1'b1;
      end
      S_LWB: begin
        mh = 1'b1; rf_ld = 1'b1;
      end
      S_STM: begin
        mj = 2'd2; me = 1'b1; mdr_ld = 1'b1;
      end
      S_STW: mfa = 1'b1;
      S_BR: begin
        ma = 2'd2; mb = 2'd2; md = 1'b1; alu_op = ALU_ADD; mc = 3'd3; rf_ld = 1'b1;
      end
      S_BL2: begin
        ma = 2'd2; md = 1'b1; alu_op = ALU_PASS; mc = 3'd2; rf_ld = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-instruction expected state traces
// built from the instruction class, directed table, random instructions, timeout/reset.
module tb_ctrl_sequencer;

  localparam int WAIT_MAX = 15;

  localparam logic [3:0] T_IDLE = 4'd0,  T_F0  = 4'd1,  T_F1  = 4'd2,  T_F2  = 4'd3;
  localparam logic [3:0] T_DEC  = 4'd4,  T_DP  = 4'd5,  T_LSA = 4'd6,  T_LDW = 4'd7;
  localparam logic [3:0] T_LWB  = 4'd8,  T_STM = 4'd9,  T_STW = 4'd10, T_BR  = 4'd11;
  localparam logic [3:0] T_BL2  = 4'd12, T_ERR = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        cond_true = 1'b0;
  logic        moc = 1'b0;
  logic [1:0]  ma, mb, mf, mi, mj;
  logic [2:0]  mc;
  logic        md, me, mg, mh;
  logic [4:0]  alu_op;
  logic        rf_ld, ir_ld, mar_ld, mdr_ld, mfa, rw, bus_err;
  logic [3:0]  state;

  ctrl_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .cond_true(cond_true), .moc(moc),
    .ma(ma), .mb(mb), .mc(mc), .md(md), .me(me), .mf(mf), .mg(mg), .mh(mh),
    .mi(mi), .mj(mj), .alu_op(alu_op), .rf_ld(rf_ld), .ir_ld(ir_ld),
    .mar_ld(mar_ld), .mdr_ld(mdr_ld), .mfa(mfa), .rw(rw), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ma; logic [1:0] mb; logic [2:0] mc; logic md; logic me;
    logic [1:0] mf; logic mg; logic mh; logic [1:0] mi; logic [1:0] mj;
    logic [4:0] alu_op; logic rf_ld; logic ir_ld; logic mar_ld; logic mdr_ld;
    logic mfa; logic rw; logic bus_err;
  } outs_t;

  outs_t act;
  assign act = {ma, mb, mc, md, me, mf, mg, mh, mi, mj, alu_op,
                rf_ld, ir_ld, mar_ld, mdr_ld, mfa, rw, bus_err};

  typedef struct packed { logic [3:0] st; logic m; } step_t;

  typedef struct {
    logic [31:0] ir;
    logic        cond;
    int          df;
    int          dm;
    logic [3:0]  ex_state;
    logic        ex_rf;
    logic [4:0]  ex_alu;
  } vec_t;

  step_t       plan[$];
  int          ex_idx;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  cap_state;
  logic        cap_rf;
  logic [4:0]  cap_alu;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Output table straight from the per-state description of the controller.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic [31:0] i, input logic m);
    outs_t o;
    o = '0;
    case (st)
      T_F0:  begin o.ma = 2; o.md = 1; o.alu_op = 5'h0D; o.mar_ld = 1; end
      T_F1:  begin o.ma = 2; o.mb = 3; o.md = 1; o.alu_op = 5'h04; o.mc = 3;
                   o.rf_ld = 1; o.mfa = 1; o.rw = 1; end
      T_F2:  begin o.mfa = 1; o.rw = 1; o.mdr_ld = 1; o.ir_ld = m; end
      T_DP:  begin o.mb = 1; o.mc = 1; o.rf_ld = (i[24:23] == 2'b10) ? 1'b0 : 1'b1; end
      T_LSA: begin o.md = 1; o.alu_op = i[23] ? 5'h04 : 5'h02; o.mar_ld = 1; end
      T_LDW: begin o.mfa = 1; o.rw = 1; o.mdr_ld = 1; end
      T_LWB: begin o.mh = 1; o.rf_ld = 1; end
      T_STM: begin o.mj = 2; o.me = 1; o.mdr_ld = 1; end
      T_STW: begin o.mfa = 1; end
      T_BR:  begin o.ma = 2; o.mb = 2; o.md = 1; o.alu_op = 5'h04; o.mc = 3; o.rf_ld = 1; end
      T_BL2: begin o.ma = 2; o.md = 1; o.alu_op = 5'h0D; o.mc = 2; o.rf_ld = 1; end
      T_ERR: begin o.bus_err = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic rm(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic push(input logic [3:0] s, input logic m);
    step_t x;
    x.st = s;
    x.m  = m;
    plan.push_back(x);
  endtask

  // Expected trace of one instruction from F1 up to and including the next F0.
  task automatic build_plan(input logic [31:0] i, input logic c, input int df,
                            input int dm, input bit rnd);
    plan.delete();
    push(T_F1, rm(rnd));
    repeat (df) push(T_F2, 1'b0);
    push(T_F2, 1'b1);
    push(T_DEC, rm(rnd));
    ex_idx = plan.size();
    if (c) begin
      if (i[27:26] == 2'b00) begin
        push(T_DP, rm(rnd));
      end else if (i[27:26] == 2'b01) begin
        push(T_LSA, rm(rnd));
        if (i[20]) begin
          repeat (dm) push(T_LDW, 1'b0);
          push(T_LDW, 1'b1);
          push(T_LWB, rm(rnd));
        end else begin
          push(T_STM, rm(rnd));
          repeat (dm) push(T_STW, 1'b0);
          push(T_STW, 1'b1);
        end
      end else if (i[27:25] == 3'b101) begin
        push(T_BR, rm(rnd));
        if (i[24]) push(T_BL2, rm(rnd));
      end
    end
    push(T_F0, rm(rnd));
  endtask

  task automatic run_plan(input logic [31:0] i, input logic c);
    for (int k = 0; k < plan.size(); k++) begin
      @(negedge clk);
      ir = i;
      cond_true = c;
      moc = plan[k].m;
      #1;
      chk($sformatf("state@%0d", k), {28'd0, state}, {28'd0, plan[k].st});
      chk($sformatf("outs@%0d st=%0d", k, plan[k].st), {3'd0, act},
          {3'd0, exp_outs(plan[k].st, i, plan[k].m)});
      if (k == ex_idx) begin
        cap_state = state;
        cap_rf    = rf_ld;
        cap_alu   = alu_op;
      end
    end
    $display("txn ir=%h cond=%0b cycles=%0d errors=%0d", i, c, plan.size(), errors);
  endtask

  task automatic enter_f0();
    plan.delete();
    push(T_F0, 1'b0);
    ex_idx = -1;
    run_plan(32'd0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, away from any clock edge.
  task automatic reset_mid(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({name, "_state"}, {28'd0, state}, {28'd0, T_IDLE});
    chk({name, "_outs"}, {3'd0, act}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    moc = 1'b0;
    #1;
    chk({name, "_idle"}, {28'd0, state}, {28'd0, T_IDLE});
    $display("txn %s reset checked", name);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'hE0812003, 1'b1, 1,  0, T_DP,  1'b1, 5'h00};
    vecs[1]  = '{32'hE1510002, 1'b1, 0,  0, T_DP,  1'b0, 5'h00};
    vecs[2]  = '{32'hE5912004, 1'b1, 0,  2, T_LSA, 1'b0, 5'h04};
    vecs[3]  = '{32'hE5012004, 1'b1, 0,  2, T_LSA, 1'b0, 5'h02};
    vecs[4]  = '{32'hEB000010, 1'b1, 0,  0, T_BR,  1'b1, 5'h04};
    vecs[5]  = '{32'hEB000010, 1'b0, 0,  0, T_F0,  1'b0, 5'h0D};
    vecs[6]  = '{32'hEA000010, 1'b1, 2,  0, T_BR,  1'b1, 5'h04};
    vecs[7]  = '{32'hEE000000, 1'b1, 0,  0, T_F0,  1'b0, 5'h0D};
    vecs[8]  = '{32'hE2812001, 1'b1, 0,  0, T_DP,  1'b1, 5'h00};
    vecs[9]  = '{32'hE7912004, 1'b1, 0, 15, T_LSA, 1'b0, 5'h04};
    vecs[10] = '{32'hEC000000, 1'b1, 0,  0, T_F0,  1'b0, 5'h0D};
    vecs[11] = '{32'hE5012004, 1'b1, 15, 0, T_LSA, 1'b0, 5'h02};

    // Reset held for three clocks, with moc toggling to show it has no effect.
    repeat (3) begin
      @(negedge clk);
      moc = 1'($urandom_range(0, 1));
      #1;
      chk("rst_state", {28'd0, state}, {28'd0, T_IDLE});
      chk("rst_outs", {3'd0, act}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    moc = 1'b0;
    #1;
    chk("idle_state", {28'd0, state}, {28'd0, T_IDLE});
    chk("idle_outs", {3'd0, act}, 32'd0);
    enter_f0();

    for (int v = 0; v < 12; v++) begin
      build_plan(vecs[v].ir, vecs[v].cond, vecs[v].df, vecs[v].dm, 1'b0);
      run_plan(vecs[v].ir, vecs[v].cond);
      chk($sformatf("vec%0d_ex_state", v), {28'd0, cap_state}, {28'd0, vecs[v].ex_state});
      chk($sformatf("vec%0d_ex_rf", v), {31'd0, cap_rf}, {31'd0, vecs[v].ex_rf});
      chk($sformatf("vec%0d_ex_alu", v), {27'd0, cap_alu}, {27'd0, vecs[v].ex_alu});
    end

    for (int r = 0; r < 40; r++) begin
      logic [31:0] ir_r;
      logic        c_r;
      ir_r = $urandom;
      c_r  = ($urandom_range(0, 3) != 0);
      build_plan(ir_r, c_r, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'b1);
      run_plan(ir_r, c_r);
    end

    // Fetch wait with no moc: WAIT_MAX+1 cycles in F2, then the sticky trap.
    plan.delete();
    push(T_F1, 1'b0);
    repeat (WAIT_MAX + 1) push(T_F2, 1'b0);
    repeat (3) push(T_ERR, 1'b1);
    ex_idx = -1;
    run_plan(32'hE0812003, 1'b1);
    reset_mid("err_reset");
    enter_f0();

    // Reset in the middle of a fetch wait drops mfa at once.
    plan.delete();
    push(T_F1, 1'b0);
    push(T_F2, 1'b0);
    push(T_F2, 1'b0);
    ex_idx = -1;
    run_plan(32'hE0812003, 1'b1);
    reset_mid("wait_reset");
    enter_f0();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multicycle Moore control unit for the ARM-subset CPU datapath.
- Runs fetch, decode and execute for three instruction classes: data-processing, LDR/STR word and B/BL.
- Drives every datapath mux select (MA–MJ), the register-file/IR/MAR/MDR load strobes and the memory handshake (mfa/moc).
- Sits between IR/condition logic and the datapath.

Parameters:
- WAIT_MAX, 15, maximum cycles a wait state may hold without moc before the error trap.
- CNT_W, 4, width of the wait-timeout counter (must hold WAIT_MAX).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ir  in  32  current instruction register contents
- cond_true  in  1  condition field of ir satisfied by current flags
- moc  in  1  memory operation complete
- ma  out  2  MUXA select
- mb  out  2  MUXPB select
- mc  out  3  MUXC select
- md  out  1  MUXD select (1 = use alu_op)
- me, mg, mh  out  1 each  MUXE/MUXG/MUXH selects
- mf, mi, mj  out  2 each  MUXF/MUXI/MUXJ selects
- alu_op  out  5  forced ALU opcode, used when md=1
- rf_ld, ir_ld, mar_ld, mdr_ld  out  1 each  load strobes
- mfa  out  1  memory function active
- rw  out  1  1 = read, 0 = write
- bus_err  out  1  sticky timeout flag
- state  out  4  current state, for debug

Behaviour:
- Moore machine: outputs decode from the state register only. Any select or strobe not listed for a state is 0.
- Reset (rst_n=0, asynchronous): state=IDLE, wait counter=0, bus_err=0, all outputs 0. Reset during a wait state aborts the access immediately; mfa drops with no handshake completion.
- IDLE(0): no outputs asserted; next state F0.
- F0(1): ma=2 (R15), md=1, alu_op=5'h0D (pass A), mar_ld=1 → F1.
- F1(2): ma=2, mb=3 (constant), md=1, alu_op=5'h04 (ADD), mc=3 (R15), rf_ld=1, mfa=1, rw=1 → F2.
- F2(3): mfa=1, rw=1, mdr_ld=1.
  - moc=1: ir_ld=1 → DEC.
  - moc=0: stay in F2.
- DEC(4), IR class taken from ir[27:25]:
  - cond_true=0 → F0 (instruction skipped).
  - 00x → DP.
  - 01x → LSA.
  - 101 → BR.
  - anything else → F0 (undefined opcode treated as NOP).
- DP(5): ma=0, mb=1 (shifter), md=0, mc=1 (Rd), rf_ld=1, except compare opcodes ir[24:23]=2'b10 keep rf_ld=0 → F0.
- LSA(6): ma=0, mb=0, md=1, alu_op=ADD if ir[23]=1 else SUB (5'h02), mar_ld=1.
  - ir[20]=1 → LDW.
  - ir[20]=0 → STM.
- LDW(7): mfa=1, rw=1, mdr_ld=1.
  - moc=1 → LWB.
  - moc=0: stay in LDW.
- LWB(8): mh=1 (MDR path), mc=0, rf_ld=1 → F0.
- STM(9): mj=2 (Rd source), me=1, mdr_ld=1 → STW.
- STW(10): mfa=1, rw=0.
  - moc=1 → F0.
  - moc=0: stay in STW.
- BR(11): ma=2, mb=2 (sign-extended offset×4), md=1, alu_op=ADD, mc=3, rf_ld=1.
  - ir[24]=1 (BL) → BL2.
  - ir[24]=0 → F0.
- BL2(12): ma=2, md=1, alu_op=5'h0D, mc=2 (R14), rf_ld=1 → F0.
- ERR(15): all outputs 0, bus_err=1. Only reset leaves ERR.
- Wait counter (F2, LDW, STW):
  - Clears on entry to any wait state.
  - Increments each cycle the machine remains in the state with moc=0.
  - On the cycle the count equals WAIT_MAX with moc=0, next state is ERR.
  - moc=1 on that same cycle wins: normal transition.
- moc seen outside a wait state: ignored.
- Unused encodings 13 and 14 → IDLE on the next clock.

Test Plan:
- Reset/fetch: hold rst_n=0 for 3 clocks, release, moc pulse in the 2nd F2 cycle → state sequence 0,1,2,3,3,4; ir_ld=1 only in the last F2 cycle; all outputs 0 while in reset.
- Data-processing: ir=32'hE0812003 (ADD), cond_true=1 → DEC→DP with rf_ld=1, mb=1, md=0. Same with CMP ir=32'hE1510002 → rf_ld=0.
- Load: ir=32'hE5912004, moc after 2 cycles → LSA alu_op=5'h04 mar_ld=1, LDW mfa=1 rw=1 for 3 cycles, LWB rf_ld=1, back to F0.
- Store with ir[23]=0: ir=32'hE5012004 → alu_op=5'h02, STM, STW with rw=0, exits on moc.
- BL: ir=32'hEB000010 → BR rf_ld mc=3, then BL2 mc=2 rf_ld=1. With cond_true=0 → DEC goes straight to F0.
- Timeout: in F2 hold moc=0 for WAIT_MAX+1 cycles → state=15, bus_err=1 and stays set; rst_n pulse low mid-ERR → state=0, bus_err=0 asynchronously.
